// File: rtl/sancus_dma_controller_if.sv
// Bus bundle between the DMA peripheral / data memory and the DMA engine.
// The master modport is the engine's view; slave is the peripheral and memory side.
interface sancus_dma_controller_if;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic        dma_end_flag;
  logic        dma_error_flag;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;

  modport master (
    input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
           dma_dout, dma_ready, dma_resp,
    output dev_in, dma_ack, dma_end_flag, dma_error_flag, dma_addr, dma_din, dma_en,
           dma_we, dma_priority
  );

  modport slave (
    output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
           dma_dout, dma_ready, dma_resp,
    input  dev_in, dma_ack, dma_end_flag, dma_error_flag, dma_addr, dma_din, dma_en,
           dma_we, dma_priority
  );
endinterface

// File: rtl/sancus_dma_controller.sv
// Memory-side DMA engine: moves 16-bit words between the DMA peripheral and data memory
// through the CPU DMA port, one handshaked word at a time, with error and timeout reporting.
module sancus_dma_controller #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 16'hFFFF
) (
  input logic                    i_clk,
  input logic                    i_reset,
  sancus_dma_controller_if.master io_bus
);

  typedef enum logic [3:0] {
    StIdle,
    StWaitDev,
    StWrMem,
    StRdMem,
    StRdData,
    StWaitAcc,
    StDone,
    StErr,
    StHold
  } state_e;

  localparam logic [15:0] WaitLimit = 16'(MAX_WAIT);
  localparam logic [1:0]  LatLast   = 2'(READ_LAT - 1);

  state_e      r_state;
  logic [14:0] r_addr;
  logic [15:0] r_cnt;
  logic        r_dir;
  logic [15:0] r_wait;
  logic [1:0]  r_lat;
  logic        r_en;
  logic [1:0]  r_we;
  logic [15:0] r_din;
  logic [15:0] r_dev_in;
  logic        r_ack;
  logic        r_end;
  logic        r_err;

  logic w_timeout;
  logic w_last;
  logic w_unused_addr0;

  // Byte address bit 0 carries no information for word transfers.
  assign w_unused_addr0 = io_bus.dma_start_address[0];
  assign w_timeout      = (r_wait + 16'd1) == WaitLimit;
  assign w_last         = r_cnt == 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_wait   <= '0;
      r_lat    <= '0;
      r_en     <= 1'b0;
      r_we     <= 2'b00;
      r_din    <= '0;
      r_dev_in <= '0;
      r_ack    <= 1'b0;
      r_end    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_end  <= 1'b0;
      r_err  <= 1'b0;
      // The wait counter only survives a cycle in which a waiting state holds.
      r_wait <= '0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.dma_rqst) begin
            r_addr <= io_bus.dma_start_address[15:1];
            r_cnt  <= io_bus.dma_num_words;
            r_dir  <= io_bus.dma_rd_wr;
            if (io_bus.dma_num_words == 16'd0) begin
              r_state <= StDone;
            end else if (io_bus.dma_rd_wr) begin
              r_en    <= 1'b1;
              r_we    <= 2'b00;
              r_state <= StRdMem;
            end else begin
              r_state <= StWaitDev;
            end
          end
        end

        StWaitDev: begin
          if (!io_bus.dma_rqst) begin
            r_state <= StIdle;
          end else if (io_bus.dev_ack) begin
            r_din   <= io_bus.dev_out;
            r_en    <= 1'b1;
            r_we    <= 2'b11;
            r_state <= StWrMem;
          end else if (w_timeout) begin
            r_state <= StErr;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        StWrMem: begin
          if (!io_bus.dma_rqst) begin
            r_en    <= 1'b0;
            r_we    <= 2'b00;
            r_state <= StIdle;
          end else if (io_bus.dma_ready) begin
            r_en <= 1'b0;
            r_we <= 2'b00;
            if (io_bus.dma_resp) begin
              r_state <= StErr;
            end else begin
              r_ack  <= 1'b1;
              r_addr <= r_addr + 15'd1;
              r_cnt  <= r_cnt - 16'd1;
              if (w_last) begin
                r_state <= StDone;
              end else if (r_dir) begin
                r_en    <= 1'b1;
                r_state <= StRdMem;
              end else begin
                r_state <= StWaitDev;
              end
            end
          end else if (w_timeout) begin
            r_en    <= 1'b0;
            r_we    <= 2'b00;
            r_state <= StErr;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        StRdMem: begin
          if (!io_bus.dma_rqst) begin
            r_en    <= 1'b0;
            r_state <= StIdle;
          end else if (io_bus.dma_ready) begin
            r_en <= 1'b0;
            if (io_bus.dma_resp) begin
              r_state <= StErr;
            end else begin
              r_lat   <= '0;
              r_state <= StRdData;
            end
          end else if (w_timeout) begin
            r_en    <= 1'b0;
            r_state <= StErr;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        StRdData: begin
          if (!io_bus.dma_rqst) begin
            r_state <= StIdle;
          end else if (r_lat == LatLast) begin
            r_dev_in <= io_bus.dma_dout;
            r_state  <= StWaitAcc;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end

        StWaitAcc: begin
          if (!io_bus.dma_rqst) begin
            r_state <= StIdle;
          end else if (io_bus.dev_ack) begin
            r_ack  <= 1'b1;
            r_addr <= r_addr + 15'd1;
            r_cnt  <= r_cnt - 16'd1;
            if (w_last) begin
              r_state <= StDone;
            end else if (r_dir) begin
              r_en    <= 1'b1;
              r_we    <= 2'b00;
              r_state <= StRdMem;
            end else begin
              r_state <= StWaitDev;
            end
          end else if (w_timeout) begin
            r_state <= StErr;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        StDone: begin
          r_end   <= 1'b1;
          r_state <= StHold;
        end

        StErr: begin
          r_err   <= 1'b1;
          r_state <= StHold;
        end

        StHold: begin
          // A request left high after completion must not start a second transfer.
          if (!io_bus.dma_rqst) begin
            r_state <= StIdle;
          end
        end

        default: begin
          r_en    <= 1'b0;
          r_we    <= 2'b00;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.dev_in         = r_dev_in;
  assign io_bus.dma_ack        = r_ack;
  assign io_bus.dma_end_flag   = r_end;
  assign io_bus.dma_error_flag = r_err;
  assign io_bus.dma_addr       = r_addr;
  assign io_bus.dma_din        = r_din;
  assign io_bus.dma_en         = r_en;
  assign io_bus.dma_we         = r_we;
  assign io_bus.dma_priority   = 1'b0;

endmodule

// File: tb/tb_sancus_dma_controller.sv
// Directed bench for sancus_dma_controller with a small word-memory model on the DMA port.
module tb_sancus_dma_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sancus_dma_controller_if bus ();

  sancus_dma_controller #(
    .READ_LAT (1),
    .MAX_WAIT (32)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: preload port plus the DMA port, read data valid one cycle after accept.
  logic [15:0] mem [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.dma_en && bus.dma_ready && !bus.dma_resp) begin
      if (bus.dma_we == 2'b11) mem[bus.dma_addr] <= bus.dma_din;
      else bus.dma_dout <= mem[bus.dma_addr];
    end
  end

  // Monitor: counts pulses and logs accepted accesses; tasks compare against snapshots.
  int          n_ack = 0, n_end = 0, n_err = 0, n_overlap = 0;
  logic [14:0] acc_addr[$];
  logic [1:0]  acc_we[$];
  logic [15:0] ack_devin[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dma_ack) begin
        n_ack++;
        ack_devin.push_back(bus.dev_in);
      end
      if (bus.dma_end_flag) n_end++;
      if (bus.dma_error_flag) n_err++;
      if (bus.dma_ack && bus.dma_end_flag) n_overlap++;
      if (bus.dma_en && bus.dma_ready) begin
        acc_addr.push_back(bus.dma_addr);
        acc_we.push_back(bus.dma_we);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic start(input logic rd_wr, input logic [15:0] addr, input logic [15:0] num);
    bus.dma_rd_wr = rd_wr;
    bus.dma_start_address = addr;
    bus.dma_num_words = num;
    bus.dma_rqst = 1'b1;
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    while (!bus.dma_end_flag && t < 100) begin tick(); t++; end
    checks++;
    if (!bus.dma_end_flag) begin
      errors++;
      $display("FAIL %s_end_timeout: no dma_end_flag within 100 cycles", name);
    end
    tick();
  endtask

  task automatic test_reset();
    tick(2);
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.dma_en, bus.dma_we, bus.dma_addr, bus.dma_din, bus.dev_in, bus.dma_ack,
         bus.dma_end_flag, bus.dma_error_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h din=%h dev_in=%h ack=%b end=%b err=%b, want all 0",
               bus.dma_en, bus.dma_we, bus.dma_addr, bus.dma_din, bus.dev_in, bus.dma_ack,
               bus.dma_end_flag, bus.dma_error_flag);
    end
    checks++;
    if (bus.dma_priority !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got %b want 0", bus.dma_priority);
    end
  endtask

  task automatic test_read();
    logic [15:0] exp_d[3] = '{16'h00A1, 16'h00B2, 16'h00C3};
    int a0, k0, e0, o0;
    for (int i = 0; i < 3; i++) preload(15'h100 + 15'(i), exp_d[i]);
    a0 = acc_addr.size(); k0 = n_ack; e0 = n_end; o0 = n_overlap;
    bus.dev_ack = 1'b1;
    start(1'b1, 16'h0200, 16'd3);
    wait_end("read");
    checks++;
    if (n_ack - k0 != 3) begin
      errors++; $display("FAIL read_ack_count: got %0d want 3", n_ack - k0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_addr[a0 + i] !== 15'h100 + 15'(i)) begin
        errors++;
        $display("FAIL read_addr%0d: got %h want %h", i, acc_addr[a0 + i], 15'h100 + 15'(i));
      end
      checks++;
      if (ack_devin[k0 + i] !== exp_d[i]) begin
        errors++;
        $display("FAIL read_dev_in%0d: got %h want %h", i, ack_devin[k0 + i], exp_d[i]);
      end
    end
    checks++;
    if (n_end - e0 != 1 || n_overlap != o0) begin
      errors++;
      $display("FAIL read_end: ends %0d overlaps %0d, want 1 and 0", n_end - e0, n_overlap - o0);
    end
    bus.dma_rqst = 1'b0;
    tick(2);
  endtask

  task automatic test_write();
    logic [15:0] words[2] = '{16'h1234, 16'h5678};
    int a0, k0, e0, idx;
    logic en_prev;
    a0 = acc_addr.size(); k0 = n_ack; e0 = n_end;
    idx = 0; en_prev = 1'b0;
    bus.dev_out = words[0];
    bus.dev_ack = 1'b1;
    start(1'b0, 16'h0300, 16'd2);
    for (int t = 0; t < 100 && !bus.dma_end_flag; t++) begin
      tick();
      // Next word is presented once the engine has captured the current one.
      if (bus.dma_en && !en_prev && idx < 1) begin
        idx++;
        bus.dev_out = words[idx];
      end
      en_prev = bus.dma_en;
    end
    checks++;
    if (!bus.dma_end_flag) begin
      errors++; $display("FAIL write_end_timeout: no dma_end_flag within 100 cycles");
    end
    tick();
    checks++;
    if (mem[15'h180] !== 16'h1234 || mem[15'h181] !== 16'h5678) begin
      errors++;
      $display("FAIL write_mem: got %h %h want 1234 5678", mem[15'h180], mem[15'h181]);
    end
    checks++;
    if (acc_we.size() - a0 != 2 || acc_we[a0] !== 2'b11 || acc_we[a0 + 1] !== 2'b11) begin
      errors++; $display("FAIL write_we: got %0d accepts, we %b %b want 2 of 11",
                         acc_we.size() - a0, acc_we[a0], acc_we[a0 + 1]);
    end
    checks++;
    if (n_ack - k0 != 2 || n_end - e0 != 1) begin
      errors++; $display("FAIL write_pulses: ack %0d end %0d want 2 and 1", n_ack - k0, n_end - e0);
    end
    bus.dma_rqst = 1'b0;
    tick(2);
  endtask

  task automatic test_zero_words();
    logic [2:0] exp_end = 3'b010;
    int a0 = acc_addr.size();
    start(1'b1, 16'h0400, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.dma_end_flag !== exp_end[i] || bus.dma_en !== 1'b0) begin
        errors++;
        $display("FAIL zero_cycle%0d: end=%b en=%b want end=%b en=0", i + 1, bus.dma_end_flag,
                 bus.dma_en, exp_end[i]);
      end
    end
    bus.dma_rqst = 1'b0;
    tick(3);
    checks++;
    if (acc_addr.size() != a0 || bus.dma_end_flag !== 1'b0) begin
      errors++; $display("FAIL zero_idle: accesses %0d end=%b want 0 and 0",
                         acc_addr.size() - a0, bus.dma_end_flag);
    end
  endtask

  task automatic test_stall_error();
    logic [14:0] held;
    int k0 = n_ack, r0 = n_err, t = 0;
    bus.dma_ready = 1'b0;
    start(1'b1, 16'h0400, 16'd1);
    while (!bus.dma_en && t < 20) begin tick(); t++; end
    held = bus.dma_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.dma_en !== 1'b1 || bus.dma_addr !== 15'h200 || held !== 15'h200) begin
        errors++;
        $display("FAIL stall_hold%0d: en=%b addr=%h want en=1 addr=200", i, bus.dma_en, bus.dma_addr);
      end
    end
    bus.dma_ready = 1'b1;
    bus.dma_resp = 1'b1;
    tick();
    bus.dma_resp = 1'b0;
    t = 0;
    while (!bus.dma_error_flag && t < 20) begin tick(); t++; end
    tick();
    checks++;
    if (n_err - r0 != 1 || n_ack != k0) begin
      errors++; $display("FAIL stall_error: err %0d ack %0d want 1 and 0", n_err - r0, n_ack - k0);
    end
    bus.dma_rqst = 1'b0;
    tick(2);
  endtask

  task automatic test_wrap();
    int a0, k0;
    preload(15'h7FFF, 16'h1111);
    preload(15'h0000, 16'h2222);
    a0 = acc_addr.size(); k0 = n_ack;
    bus.dev_ack = 1'b1;
    start(1'b1, 16'hFFFE, 16'd2);
    wait_end("wrap");
    checks++;
    if (acc_addr[a0] !== 15'h7FFF || acc_addr[a0 + 1] !== 15'h0000) begin
      errors++; $display("FAIL wrap_addr: got %h %h want 7fff 0000", acc_addr[a0], acc_addr[a0 + 1]);
    end
    checks++;
    if (ack_devin[k0] !== 16'h1111 || ack_devin[k0 + 1] !== 16'h2222) begin
      errors++; $display("FAIL wrap_data: got %h %h want 1111 2222", ack_devin[k0], ack_devin[k0 + 1]);
    end
    bus.dma_rqst = 1'b0;
    tick(2);
  endtask

  task automatic test_abort_wait_acc();
    int k0 = n_ack, e0 = n_end, r0 = n_err, a0, t = 0;
    bus.dev_ack = 1'b0;
    start(1'b1, 16'h0500, 16'd3);
    while (!bus.dma_en && t < 20) begin tick(); t++; end
    tick(3);  // accept, read-data capture, now waiting on the device
    a0 = acc_addr.size();
    bus.dma_rqst = 1'b0;
    tick(4);
    checks++;
    if (n_ack != k0 || n_end != e0 || n_err != r0 || bus.dma_en !== 1'b0) begin
      errors++; $display("FAIL abort_flags: ack %0d end %0d err %0d en %b want all 0",
                         n_ack - k0, n_end - e0, n_err - r0, bus.dma_en);
    end
    checks++;
    if (acc_addr.size() != a0) begin
      errors++; $display("FAIL abort_idle: %0d accesses after abort want 0", acc_addr.size() - a0);
    end
  endtask

  task automatic test_timeout();
    int r0 = n_err, k0 = n_ack, t = 0;
    bus.dev_ack = 1'b0;
    start(1'b0, 16'h0600, 16'd1);
    while (!bus.dma_error_flag && t < 60) begin tick(); t++; end
    checks++;
    if (t < 32 || t > 36) begin
      errors++; $display("FAIL timeout_latency: error after %0d cycles want 32..36", t);
    end
    tick();
    checks++;
    if (n_err - r0 != 1 || n_ack != k0) begin
      errors++; $display("FAIL timeout_flags: err %0d ack %0d want 1 and 0", n_err - r0, n_ack - k0);
    end
    bus.dma_rqst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_write();
    int e0 = n_end, r0 = n_err;
    bus.dma_ready = 1'b0;
    bus.dev_ack = 1'b1;
    bus.dev_out = 16'hBEEF;
    start(1'b0, 16'h0700, 16'd1);
    tick(2);
    checks++;
    if (bus.dma_en !== 1'b1 || bus.dma_we !== 2'b11 || bus.dma_din !== 16'hBEEF) begin
      errors++; $display("FAIL midrst_setup: en=%b we=%b din=%h want 1 11 beef",
                         bus.dma_en, bus.dma_we, bus.dma_din);
    end
    rst = 1'b1;
    bus.dma_rqst = 1'b0;
    tick();
    checks++;
    if ({bus.dma_en, bus.dma_we, bus.dma_addr, bus.dma_din, bus.dev_in, bus.dma_ack,
         bus.dma_end_flag, bus.dma_error_flag} !== '0) begin
      errors++; $display("FAIL midrst_outputs: en=%b we=%b addr=%h din=%h dev_in=%h want all 0",
                         bus.dma_en, bus.dma_we, bus.dma_addr, bus.dma_din, bus.dev_in);
    end
    rst = 1'b0;
    bus.dma_ready = 1'b1;
    tick(4);
    checks++;
    if (n_end != e0 || n_err != r0) begin
      errors++; $display("FAIL midrst_flags: end %0d err %0d want 0 and 0", n_end - e0, n_err - r0);
    end
  endtask

  initial begin
    bus.dma_rqst = 1'b0;
    bus.dma_rd_wr = 1'b0;
    bus.dma_start_address = '0;
    bus.dma_num_words = '0;
    bus.dev_ack = 1'b0;
    bus.dev_out = '0;
    bus.dma_ready = 1'b1;
    bus.dma_resp = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_zero_words();
    test_stall_error();
    test_wrap();
    test_abort_wait_acc();
    test_timeout();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
